// File: rtl/cpu_pkg.sv
// Shared CPU definitions: M-extension divide op encodings, funct3 values and
// the divider state encoding.
package cpu_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIN  = 2'd2,
    DIV_FAST = 2'd3
  } div_state_e;

  // The divide funct3 values were chosen so their low two bits are the op code.
  function automatic logic [1:0] div_op_from_funct3(input logic [2:0] funct3);
    return funct3[1:0];
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration, purely combinational.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] dvs,
  output logic [W:0]   rem_next,
  output logic [W-1:0] quo_next
);

  logic [W+1:0] shifted;
  logic [W+1:0] diff;

  assign shifted = {rem, quo[W-1]};
  assign diff    = shifted - {2'b00, dvs};

  // The top bit of diff is the borrow: set means the trial subtract failed.
  always_comb begin
    if (!diff[W+1]) begin
      rem_next = diff[W:0];
      quo_next = {quo[W-2:0], 1'b1};
    end else begin
      rem_next = shifted[W:0];
      quo_next = {quo[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), restoring radix-2 with a
// fast path for divide-by-zero and signed overflow. Optional DIV_DBZ_FLAG_EN adds dbz.
module div_unit
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
`ifdef DIV_DBZ_FLAG_EN
  output logic                  dbz,
`endif
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH);

  div_state_e state, state_next;

  logic [CNT_WIDTH-1:0] cnt;
  logic [W:0]           rem_q, rem_nx;
  logic [W-1:0]         quo_q, quo_nx;
  logic [W-1:0]         dvs_q;
  logic [W-1:0]         fast_q;
  logic [W-1:0]         result_q;
  logic                 is_rem_q, neg_quo_q, neg_rem_q;
`ifdef DIV_DBZ_FLAG_EN
  logic                 dbz_q;
`endif

  logic         is_signed, a_neg, b_neg, div_zero, ovf, accept;
  logic [W-1:0] abs_a, abs_b, fast_val, final_val;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & dividend[W-1];
  assign b_neg     = is_signed & divisor[W-1];
  assign abs_a     = a_neg ? -dividend : dividend;
  assign abs_b     = b_neg ? -divisor : divisor;
  assign div_zero  = (divisor == '0);
  assign ovf       = is_signed && (dividend == {1'b1, {(W-1){1'b0}}}) && (divisor == '1);
  // Overflow DIV returns the most negative value, which is the dividend itself.
  assign fast_val  = div_zero ? (op[1] ? dividend : '1) : (op[1] ? '0 : dividend);
  assign accept    = start & ~flush & (state == DIV_IDLE);

  div_step #(.W(W)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dvs      (dvs_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      DIV_IDLE: if (accept) state_next = (div_zero || ovf) ? DIV_FAST : DIV_CALC;
      DIV_CALC: if (cnt == LAST_CNT) state_next = DIV_FIN;
      DIV_FIN:  state_next = DIV_IDLE;
      DIV_FAST: state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
    if (flush) state_next = DIV_IDLE;
  end

  always_comb begin
    final_val = fast_q;
    if (state != DIV_FAST) begin
      if (is_rem_q) final_val = neg_rem_q ? -rem_q[W-1:0] : rem_q[W-1:0];
      else          final_val = neg_quo_q ? -quo_q : quo_q;
    end
  end

  assign busy   = (state != DIV_IDLE);
  assign done   = ((state == DIV_FIN) || (state == DIV_FAST)) && !flush;
  assign result = done ? final_val : result_q;
`ifdef DIV_DBZ_FLAG_EN
  assign dbz    = done & dbz_q;
`endif

  // NOTE: the datapath is a handful of flops, not a memory, so all of it is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      fast_q    <= '0;
      result_q  <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`ifdef DIV_DBZ_FLAG_EN
      dbz_q     <= 1'b0;
`endif
    end else begin
      if (accept) begin
        cnt       <= '0;
        rem_q     <= '0;
        quo_q     <= abs_a;
        dvs_q     <= abs_b;
        fast_q    <= fast_val;
        is_rem_q  <= op[1];
        neg_quo_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
`ifdef DIV_DBZ_FLAG_EN
        dbz_q     <= div_zero;
`endif
      end else if (state == DIV_CALC && cnt != LAST_CNT) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt   <= cnt + CNT_WIDTH'(1);
      end
      if (done) result_q <= final_val;
    end
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle RV32M divider covering DIV, DIVU, REM and REMU.
- Sits in EX, upstream of the EX/WB result-select mux. The mux data input for "M-extension divide" is driven from result; the stall logic watches busy.
- Radix-2 restoring algorithm, one quotient bit per cycle, with a fast path for RISC-V special cases.

Parameters:
- DATA_WIDTH, 32: operand and result width; must be even and >= 8.
- CNT_WIDTH, 6: iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start.
- dividend  input  DATA_WIDTH  rs1 value; sampled with start.
- divisor  input  DATA_WIDTH  rs2 value; sampled with start.
- flush  input  1  pipeline kill; aborts the operation in flight.
- busy  output  1  high while the operation is not yet complete.
- done  output  1  one-cycle pulse; result is valid in that cycle.
- result  output  DATA_WIDTH  quotient or remainder; holds until the next done.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, counter=0, internal registers=0.
- Interface conventions: clk and rst as above, one clock domain, reset synchronous and active-high.
- States: IDLE, CALC, FIN, FAST.
- IDLE:
  - start=1 and flush=0: latch op and operands, compute absolute values for signed ops, record the quotient and remainder signs.
  - Divisor==0, or op==DIV/REM with dividend==100..0 and divisor==all-ones: go to FAST.
  - Otherwise go to CALC with counter=0.
- CALC:
  - One iteration per cycle: shift {rem,quo} left by 1, trial-subtract |divisor|; quotient LSB=1 if no borrow, else restore.
  - Counter increments each cycle; after DATA_WIDTH iterations, go to FIN.
- FIN:
  - Apply signs: quotient negative iff signed op and operand signs differ; remainder takes the dividend's sign.
  - Register result, pulse done, go to IDLE.
- FAST:
  - Register the special result, pulse done, go to IDLE.
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give the dividend unchanged.
  - Signed overflow: DIV gives 100..0; REM gives 0.
- Latency, with start sampled in cycle 0:
  - Normal: done high in cycle DATA_WIDTH+2 (34 at default).
  - FAST: done high in cycle 1.
- busy: 1 from cycle 1 up to and including the done cycle; 0 in IDLE otherwise. A new start is accepted in the done cycle's successor, not in the done cycle.
- start while busy=1: ignored; no queuing.
- flush:
  - Any state: next state=IDLE, busy=0, no done, result unchanged.
  - flush and start in the same cycle: flush wins, start dropped.
  - flush in the FIN or FAST cycle suppresses that done.
- rst mid-operation: identical to the reset values, with result cleared.
- Width rules: partial remainder is DATA_WIDTH+1 bits to hold the borrow. Negation is two's complement modulo 2^DATA_WIDTH.

Optional Feature:
- Macro: DIV_DBZ_FLAG_EN.
- Defined: extra output port dbz (1 bit). It is registered, high exactly in done cycles produced by a divisor==0 request, 0 otherwise, and reset to 0.
- Not defined: port absent; all other behaviour identical.

Decomposition:
- Shared package (cpu_pkg):
  - op encodings DIV_OP_DIV/DIVU/REM/REMU.
  - div state encoding (IDLE, CALC, FIN, FAST as 2-bit constants).
  - M-extension funct3 values used by the decoder to build op.
- Sub-module: div_step. Purely combinational single restoring iteration: inputs partial remainder, quotient, divisor; outputs next partial remainder and next quotient.
- div_unit owns the FSM, counter, sign handling and output registers.

Test Plan:
- DIVU 100 / 7, start in cycle 0: busy high cycles 1-34, done only in cycle 34, result=14; REMU same operands gives 2.
- DIV -7 / 2 gives -3 (0xFFFFFFFD); REM -7 / 2 gives -1 (0xFFFFFFFF); REM 7 / -2 gives 1.
- DIV 0x80000000 / 0xFFFFFFFF: done in cycle 1, result=0x80000000; REM of the same gives 0. DIVU 5/0 gives 0xFFFFFFFF; REMU 5/0 gives 5, done in cycle 1 (dbz=1 when DIV_DBZ_FLAG_EN is defined).
- Start DIVU 1000/3, flush in cycle 10: busy=0 in cycle 11, no done ever, result keeps its previous value. Start plus flush in the same cycle: busy stays 0.
- Second start asserted in cycles 5-20 during an operation: ignored, first result (1000/3=333) delivered. Start in the cycle after done is accepted.
- rst asserted in cycle 15 of an operation: next cycle busy=0, done=0, result=0; an operation started afterwards completes normally.
